// File: rtl/pc_unit_if.sv
// Fetch-sequencer bus between pc_unit and its controller.
// Counter signals exist only when PC_UNIT_PERF_EN is defined.
interface pc_unit_if #(
   parameter int PC_W = 12
);
   logic            start;
   logic            stall;
   logic            halt;
   logic            branch_en;
   logic [PC_W-1:0] branch_pos;
   logic [PC_W-1:0] pc;
   logic            fetch_valid;
   logic            busy;
   logic            done;
`ifdef PC_UNIT_PERF_EN
   logic [15:0]     cycle_cnt;
   logic [15:0]     branch_cnt;
`endif

   modport master (
      output start, stall, halt, branch_en, branch_pos,
`ifdef PC_UNIT_PERF_EN
      input  cycle_cnt, branch_cnt,
`endif
      input  pc, fetch_valid, busy, done
   );

   modport slave (
      input  start, stall, halt, branch_en, branch_pos,
`ifdef PC_UNIT_PERF_EN
      output cycle_cnt, branch_cnt,
`endif
      output pc, fetch_valid, busy, done
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter / fetch sequencer with IDLE/RUN/DONE start-done handshake.
// Optional PC_UNIT_PERF_EN adds saturating RUN-cycle and taken-branch counters.
module pc_unit #(
   parameter int              PC_W       = 12,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input logic     clk,
   input logic     reset,
   pc_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            done_q, done_d;
   logic            start_acc;
   logic            branch_acc;

   // start is only honoured outside RUN; a branch only counts when it moves pc
   assign start_acc  = (state_q != RUN) && bus.start;
   assign branch_acc = (state_q == RUN) && !bus.halt && !bus.stall && bus.branch_en;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = done_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            if (bus.halt) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (bus.stall) begin
               pc_d = pc_q;
            end else if (bus.branch_en) begin
               pc_d = bus.branch_pos;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = START_ADDR;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= START_ADDR;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.done        = done_q;
   assign bus.busy        = (state_q == RUN);
   assign bus.fetch_valid = (state_q == RUN);

`ifdef PC_UNIT_PERF_EN
   logic [15:0] cycle_cnt_q, cycle_cnt_d;
   logic [15:0] branch_cnt_q, branch_cnt_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      branch_cnt_d = branch_cnt_q;
      if (start_acc) begin
         cycle_cnt_d  = '0;
         branch_cnt_d = '0;
      end else if (state_q == RUN) begin
         cycle_cnt_d = sat_inc(cycle_cnt_q);
         if (branch_acc) branch_cnt_d = sat_inc(branch_cnt_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt_q  <= '0;
         branch_cnt_q <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         branch_cnt_q <= branch_cnt_d;
      end
   end

   assign bus.cycle_cnt  = cycle_cnt_q;
   assign bus.branch_cnt = branch_cnt_q;
`else
   logic unused_ok;
   assign unused_ok = start_acc ^ branch_acc;
`endif

endmodule
